sequenciador_servo: RTL and testbench
=====================================

SEQUENCIADOR_SERVO -- requirements
Module: sequenciador_servo

Interface
REQ-001 Parameter CONF_PERIODO, default 1000000: PWM period in clock cycles; equals the period used by the driven PWM generator.
REQ-002 Parameter PERIODOS_POR_PASSO, default 50: number of PWM periods each sweep position is held (50 = 1 s at 20 ms).
REQ-003 clock  input  1  system clock, 50 MHz, rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the clock rising edge.
REQ-005 iniciar  input  1  start a sweep; level sampled every cycle.
REQ-006 parar  input  1  abort the sweep; level sampled every cycle.
REQ-007 continuo  input  1  1 = repeat the sweep indefinitely, 0 = run a single sweep.
REQ-008 largura  output  2  width code to the PWM generator; registered.
REQ-009 ativo  output  1  high in states PREPARA and ESPERA.
REQ-010 fim_varredura  output  1  one-cycle pulse on sweep completion or abort.
REQ-011 db_estado  output  2  current state encoding, for debug.

Function
REQ-012 Period tick: a free-running counter SHALL count 0..CONF_PERIODO-1 and wrap; tick is high in the cycle where count = CONF_PERIODO-1.
REQ-013 Position table: idx 0..4 SHALL map to largura codes 01, 10, 11, 10, 01.
REQ-014 States: INICIAL=0, PREPARA=1, ESPERA=2, FIM=3.
REQ-015 INICIAL: largura = 00. If iniciar=1 and parar=0, go to PREPARA on the next edge; parar has priority over iniciar.
REQ-016 PREPARA: wait for tick. On the tick edge: largura <= table[0], idx <= 0, dwell counter <= 0, go to ESPERA.
REQ-017 ESPERA, on a tick with dwell < PERIODOS_POR_PASSO-1: dwell increments.
REQ-018 ESPERA, on a tick with dwell = PERIODOS_POR_PASSO-1: dwell <= 0, and
  - idx < 4: idx increments and largura <= table[idx+1];
  - idx = 4 and continuo=1: idx <= 1 and largura <= table[1];
  - idx = 4 and continuo=0: largura <= 00 and go to FIM.
REQ-019 Each position SHALL hold exactly PERIODOS_POR_PASSO ticks; largura SHALL change only on tick edges during a sweep.
REQ-020 continuo is sampled only at the idx=4 wrap decision.
REQ-021 parar=1 in PREPARA or ESPERA: on the next edge, largura <= 00 and go to FIM, regardless of tick.
REQ-022 FIM: fim_varredura=1 for exactly one cycle, then go to INICIAL unconditionally.
REQ-023 iniciar is ignored in PREPARA, ESPERA and FIM; it does not restart or queue a sweep.
REQ-024 dwell counter width: ceil(log2(PERIODOS_POR_PASSO)) bits, minimum 1. Period counter: 32 bits.

Reset
REQ-025 With reset=0 at a rising edge, the following SHALL hold after that edge: state=INICIAL, largura=00, ativo=0, fim_varredura=0, idx=0, dwell=0, period counter=0.
REQ-026 Reset asserted mid-sweep SHALL abort with no fim_varredura pulse.
REQ-027 The period counter restarts at 0 on reset so that it aligns with a PWM generator reset on the same cycle.

Structure
REQ-028 A shared package SHALL hold the state encodings, the largura codes (00/01/10/11) and the 5-entry position table.
REQ-029 The period tick generator SHALL be one sub-module, contador_periodo (parameter CONF_PERIODO; outputs count and tick). The FSM and dwell/idx logic live in sequenciador_servo.
REQ-030 Outputs largura, ativo, fim_varredura and db_estado SHALL be registered, with no combinational path from inputs.

Verification (CONF_PERIODO=10, PERIODOS_POR_PASSO=2)
REQ-031 Single sweep: reset, then iniciar pulse with continuo=0 -> largura sequence 01,10,11,10,01, each held 20 cycles, then 00; fim_varredura pulses once; ativo falls in the same cycle.
REQ-032 Continuous: continuo=1 -> after idx 4 (01), largura goes to 10 (idx 1); no fim_varredura over 3 full loops.
REQ-033 Abort: parar while largura=11 -> largura=00 one edge later, fim_varredura the following cycle, then state INICIAL.
REQ-034 Simultaneous inputs: iniciar=parar=1 in INICIAL -> stays INICIAL. iniciar re-pulsed during ESPERA -> sequence unaffected.
REQ-035 Reset mid-sweep (reset=0 for 1 cycle during idx 2) -> all outputs at reset values, no fim_varredura pulse; next iniciar starts again at idx 0.
REQ-036 Alignment: largura transitions occur only in cycles where the period count = 9; PREPARA lasts until the first tick.

Source files
------------

// File: rtl/sequenciador_servo_pkg.sv
// Shared encodings for the servo sweep sequencer: FSM states, width codes
// and the sweep position table.
package sequenciador_servo_pkg;

  typedef enum logic [1:0] {
    INICIAL = 2'd0,
    PREPARA = 2'd1,
    ESPERA  = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [1:0] LARG_00 = 2'b00;
  localparam logic [1:0] LARG_01 = 2'b01;
  localparam logic [1:0] LARG_10 = 2'b10;
  localparam logic [1:0] LARG_11 = 2'b11;

  localparam int         NUM_POS    = 5;
  localparam logic [2:0] IDX_ULTIMO = 3'd4;

  // Entry 0 is the rightmost element: sweep goes 01,10,11,10,01.
  localparam logic [NUM_POS-1:0][1:0] TABELA_POS =
    {LARG_01, LARG_10, LARG_11, LARG_10, LARG_01};

  function automatic logic [1:0] posicao(input logic [2:0] idx);
    if (idx <= IDX_ULTIMO) return TABELA_POS[idx];
    else                   return LARG_00;
  endfunction

endpackage

// File: rtl/sequenciador_servo_contador_periodo.sv
// Free-running PWM period counter; tick marks the last cycle of each period.
module contador_periodo #(
  parameter int CONF_PERIODO = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] count,
  output logic        tick
);

  assign tick = (count == 32'(CONF_PERIODO - 1));

  always_ff @(posedge clock) begin
    if (!reset)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 32'd1;
  end

endmodule

// File: rtl/sequenciador_servo.sv
// Servo sweep sequencer: steps the PWM width code through the position table,
// holding each position for a number of PWM periods.
module sequenciador_servo
  import sequenciador_servo_pkg::*;
#(
  parameter int CONF_PERIODO       = 1000000,
  parameter int PERIODOS_POR_PASSO = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       continuo,
  output logic [1:0] largura,
  output logic       ativo,
  output logic       fim_varredura,
  output logic [1:0] db_estado
);

  localparam int DW = (PERIODOS_POR_PASSO > 1) ? $clog2(PERIODOS_POR_PASSO) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(PERIODOS_POR_PASSO - 1);

  estado_t       estado;
  logic [2:0]    idx;
  logic [DW-1:0] dwell;
  logic          tick;
  // The count itself is only needed by whoever aligns the PWM generator.
  logic [31:0]   contagem_unused;

  contador_periodo #(.CONF_PERIODO(CONF_PERIODO)) u_periodo (
    .clock (clock),
    .reset (reset),
    .count (contagem_unused),
    .tick  (tick)
  );

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= INICIAL;
      largura       <= LARG_00;
      ativo         <= 1'b0;
      fim_varredura <= 1'b0;
      idx           <= '0;
      dwell         <= '0;
    end else begin
      fim_varredura <= 1'b0;
      case (estado)
        INICIAL: begin
          largura <= LARG_00;
          if (iniciar && !parar) begin
            estado <= PREPARA;
            ativo  <= 1'b1;
          end
        end
        PREPARA, ESPERA: begin
          if (parar) begin
            estado        <= FIM;
            largura       <= LARG_00;
            ativo         <= 1'b0;
            fim_varredura <= 1'b1;
          end else if (tick) begin
            if (estado == PREPARA) begin
              estado  <= ESPERA;
              largura <= posicao(3'd0);
              idx     <= '0;
              dwell   <= '0;
            end else if (dwell != DWELL_MAX) begin
              dwell <= dwell + 1'b1;
            end else begin
              dwell <= '0;
              if (idx != IDX_ULTIMO) begin
                idx     <= idx + 3'd1;
                largura <= posicao(idx + 3'd1);
              end else if (continuo) begin
                // Loop restarts at idx 1 so the end position is not doubled.
                idx     <= 3'd1;
                largura <= posicao(3'd1);
              end else begin
                estado        <= FIM;
                largura       <= LARG_00;
                ativo         <= 1'b0;
                fim_varredura <= 1'b1;
              end
            end
          end
        end
        FIM: estado <= INICIAL;
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_servo.sv
// Directed bench for sequenciador_servo with CONF_PERIODO=10, PERIODOS_POR_PASSO=2.
module tb_sequenciador_servo;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic       continuo;
  logic [1:0] largura;
  logic       ativo;
  logic       fim_varredura;
  logic [1:0] db_estado;

  int vectors     = 0;
  int miscompares = 0;
  int fim_count   = 0;
  int fim_base    = 0;

  logic [1:0] tab [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};

  sequenciador_servo #(.CONF_PERIODO(10), .PERIODOS_POR_PASSO(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .parar         (parar),
    .continuo      (continuo),
    .largura       (largura),
    .ativo         (ativo),
    .fim_varredura (fim_varredura),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (fim_varredura === 1'b1) fim_count++;

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench on the negedge right after the reset edge (period count 0).
  task automatic do_reset();
    reset = 1'b0;
    ciclos(1);
    reset = 1'b1;
  endtask

  task automatic start();
    iniciar = 1'b1;
    ciclos(1);
    iniciar = 1'b0;
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; parar = 1'b0; continuo = 1'b0;
    ciclos(2);
    reset = 1'b1;
    chk("rst_largura", 32'(largura), 32'h0);
    chk("rst_ativo", 32'(ativo), 32'h0);
    chk("rst_fim", 32'(fim_varredura), 32'h0);
    chk("rst_estado", 32'(db_estado), 32'h0);

    // Single sweep
    start();
    chk("prep_ativo", 32'(ativo), 32'h1);
    chk("prep_estado", 32'(db_estado), 32'h1);
    ciclos(8);
    chk("prep_cnt8_largura", 32'(largura), 32'h0);
    chk("prep_cnt8_estado", 32'(db_estado), 32'h1);
    ciclos(1);
    chk("first_tick_largura", 32'(largura), 32'h1);
    chk("first_tick_estado", 32'(db_estado), 32'h2);
    for (int p = 0; p < 5; p++) begin
      ciclos(19);
      chk($sformatf("hold_end_%0d", p), 32'(largura), 32'(tab[p]));
      ciclos(1);
      if (p < 4) begin
        chk($sformatf("step_%0d", p + 1), 32'(largura), 32'(tab[p + 1]));
      end else begin
        chk("sweep_end_largura", 32'(largura), 32'h0);
        chk("sweep_end_fim", 32'(fim_varredura), 32'h1);
        chk("sweep_end_ativo", 32'(ativo), 32'h0);
        chk("sweep_end_estado", 32'(db_estado), 32'h3);
      end
    end
    ciclos(1);
    chk("post_fim_pulse", 32'(fim_varredura), 32'h0);
    chk("post_fim_estado", 32'(db_estado), 32'h0);
    chk("single_fim_count", 32'(fim_count), 32'd1);

    // Continuous: idx 4 wraps to idx 1, continuo dropped later ends the sweep
    do_reset();
    continuo = 1'b1;
    fim_base = fim_count;
    start();
    ciclos(9);
    chk("cont_first", 32'(largura), 32'h1);
    for (int k = 1; k <= 13; k++) begin
      ciclos(20);
      chk($sformatf("cont_step_%0d", k), 32'(largura), 32'(tab[((k - 1) % 4) + 1]));
    end
    chk("cont_no_fim", 32'(fim_count), 32'(fim_base));
    continuo = 1'b0;
    ciclos(80);
    chk("cont_stop_largura", 32'(largura), 32'h0);
    chk("cont_stop_fim", 32'(fim_varredura), 32'h1);
    ciclos(1);

    // Abort while largura = 11
    do_reset();
    start();
    ciclos(49);
    chk("abort_pre", 32'(largura), 32'h3);
    ciclos(5);
    parar = 1'b1;
    ciclos(1);
    parar = 1'b0;
    chk("abort_largura", 32'(largura), 32'h0);
    chk("abort_fim", 32'(fim_varredura), 32'h1);
    chk("abort_ativo", 32'(ativo), 32'h0);
    chk("abort_estado", 32'(db_estado), 32'h3);
    ciclos(1);
    chk("abort_back_estado", 32'(db_estado), 32'h0);
    chk("abort_back_fim", 32'(fim_varredura), 32'h0);

    // Simultaneous iniciar/parar, then iniciar re-pulsed mid-sweep
    do_reset();
    iniciar = 1'b1; parar = 1'b1;
    ciclos(3);
    chk("both_estado", 32'(db_estado), 32'h0);
    chk("both_ativo", 32'(ativo), 32'h0);
    iniciar = 1'b0; parar = 1'b0;
    do_reset();
    start();
    ciclos(34);
    chk("repulse_pre", 32'(largura), 32'h2);
    start();
    chk("repulse_largura", 32'(largura), 32'h2);
    chk("repulse_estado", 32'(db_estado), 32'h2);
    ciclos(14);
    chk("repulse_next", 32'(largura), 32'h3);

    // Reset during idx 2
    do_reset();
    start();
    ciclos(54);
    chk("midrst_pre", 32'(largura), 32'h3);
    fim_base = fim_count;
    reset = 1'b0;
    ciclos(1);
    reset = 1'b1;
    chk("midrst_largura", 32'(largura), 32'h0);
    chk("midrst_ativo", 32'(ativo), 32'h0);
    chk("midrst_fim", 32'(fim_varredura), 32'h0);
    chk("midrst_estado", 32'(db_estado), 32'h0);
    start();
    ciclos(9);
    chk("midrst_restart_idx0", 32'(largura), 32'h1);
    chk("midrst_no_fim", 32'(fim_count), 32'(fim_base));
    ciclos(20);
    chk("midrst_restart_idx1", 32'(largura), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
